// File: rtl/dac_sample_packer.sv
`default_nettype none
// ============================================================================
// Module   : dac_sample_packer
// Purpose  : Saturates two signed channels to DAC width, packs them into an
//            AXI-Stream word and buffers the words in a show-ahead FIFO that is
//            flushed while IAGC status reports reset. Optional ramp test
//            pattern source enabled by macro DAC_PACK_TEST_PATTERN_EN.
// Revision : 1.0 - initial release
// ============================================================================
module dac_sample_packer #(
    parameter int IN_DATA_SIZE     = 16,
    parameter int ZMOD_DATA_SIZE   = 14,
    parameter int AXIS_DATA_SIZE   = 32,
    parameter int IAGC_STATUS_SIZE = 4,
    parameter int FIFO_DEPTH       = 8
) (
    input  logic                            i_dac_clock,
    input  logic                            i_reset,
    input  logic [IAGC_STATUS_SIZE-1:0]     i_iagc_status,
    input  logic [IN_DATA_SIZE-1:0]         i_ch1_data,
    input  logic [IN_DATA_SIZE-1:0]         i_ch2_data,
    input  logic                            i_data_valid,
`ifdef DAC_PACK_TEST_PATTERN_EN
    input  logic                            i_pattern_en,
`endif
    output logic                            o_data_ready,
    output logic [AXIS_DATA_SIZE-1:0]       o_data,
    output logic                            o_data_valid,
    input  logic                            i_data_ready,
    output logic [$clog2(FIFO_DEPTH):0]     o_fifo_level,
    output logic                            o_sat_ch1,
    output logic                            o_sat_ch2,
    output logic [15:0]                     o_underrun_count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int HALF  = AXIS_DATA_SIZE / 2;
    localparam int PAD   = HALF - ZMOD_DATA_SIZE;

    localparam logic signed [IN_DATA_SIZE-1:0] SAT_MAX =
        {{(IN_DATA_SIZE-ZMOD_DATA_SIZE+1){1'b0}}, {(ZMOD_DATA_SIZE-1){1'b1}}};
    localparam logic signed [IN_DATA_SIZE-1:0] SAT_MIN =
        {{(IN_DATA_SIZE-ZMOD_DATA_SIZE+1){1'b1}}, {(ZMOD_DATA_SIZE-1){1'b0}}};

    // Returns {clipped, clamped sample}.
    function automatic logic [ZMOD_DATA_SIZE:0] saturate(input logic signed [IN_DATA_SIZE-1:0] s);
        if (s > SAT_MAX)
            saturate = {1'b1, SAT_MAX[ZMOD_DATA_SIZE-1:0]};
        else if (s < SAT_MIN)
            saturate = {1'b1, SAT_MIN[ZMOD_DATA_SIZE-1:0]};
        else
            saturate = {1'b0, s[ZMOD_DATA_SIZE-1:0]};
    endfunction

    // Each channel sits left-justified in its half-word, low bits zero.
    function automatic logic [AXIS_DATA_SIZE-1:0] pack_word(input logic [ZMOD_DATA_SIZE-1:0] a,
                                                           input logic [ZMOD_DATA_SIZE-1:0] b);
        logic [HALF-1:0] ha;
        logic [HALF-1:0] hb;
        ha = HALF'(a) << PAD;
        hb = HALF'(b) << PAD;
        pack_word = {ha, hb};
    endfunction

    logic                       active;
    logic [ZMOD_DATA_SIZE:0]    ch1_res;
    logic [ZMOD_DATA_SIZE:0]    ch2_res;
    logic                       push;
    logic                       pop;
    logic                       sat_set1;
    logic                       sat_set2;
    logic [AXIS_DATA_SIZE-1:0]  push_word;
    logic [AXIS_DATA_SIZE-1:0]  mem [FIFO_DEPTH];
    logic [PTR_W-1:0]           wr_ptr;
    logic [PTR_W-1:0]           rd_ptr;
    logic [LVL_W-1:0]           level;
    logic [LVL_W-1:0]           level_next;
    logic                       not_full;
    logic                       sat1;
    logic                       sat2;
    logic [15:0]                underrun;

    assign active  = (i_iagc_status != '0);
    assign ch1_res = saturate(i_ch1_data);
    assign ch2_res = saturate(i_ch2_data);
    assign pop     = o_data_valid && i_data_ready;

`ifdef DAC_PACK_TEST_PATTERN_EN
    logic [ZMOD_DATA_SIZE-1:0] ramp;
    logic                      pattern_mode;

    assign pattern_mode = active && i_pattern_en;
    assign o_data_ready = active && not_full && !pattern_mode;
    assign push         = pattern_mode ? not_full : (i_data_valid && o_data_ready);
    assign push_word    = pattern_mode ? pack_word(ramp, ~ramp)
                                       : pack_word(ch1_res[ZMOD_DATA_SIZE-1:0], ch2_res[ZMOD_DATA_SIZE-1:0]);
    assign sat_set1     = push && !pattern_mode && ch1_res[ZMOD_DATA_SIZE];
    assign sat_set2     = push && !pattern_mode && ch2_res[ZMOD_DATA_SIZE];

    always_ff @(posedge i_dac_clock or posedge i_reset) begin
        if (i_reset)
            ramp <= '0;
        else if (!active)
            ramp <= '0;
        else if (pattern_mode && push)
            ramp <= ramp + 1'b1;
    end
`else
    assign o_data_ready = active && not_full;
    assign push         = i_data_valid && o_data_ready;
    assign push_word    = pack_word(ch1_res[ZMOD_DATA_SIZE-1:0], ch2_res[ZMOD_DATA_SIZE-1:0]);
    assign sat_set1     = push && ch1_res[ZMOD_DATA_SIZE];
    assign sat_set2     = push && ch2_res[ZMOD_DATA_SIZE];
`endif

    always_comb begin
        level_next = level;
        if (!active)
            level_next = '0;
        else if (push && !pop)
            level_next = level + 1'b1;
        else if (!push && pop)
            level_next = level - 1'b1;
    end

    // Storage is reset so o_data reads zero out of reset.
    always_ff @(posedge i_dac_clock or posedge i_reset) begin
        if (i_reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++)
                mem[i] <= '0;
        end else if (active && push) begin
            mem[wr_ptr] <= push_word;
        end
    end

    always_ff @(posedge i_dac_clock or posedge i_reset) begin
        if (i_reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            not_full <= 1'b0;
            sat1     <= 1'b0;
            sat2     <= 1'b0;
            underrun <= '0;
        end else if (!active) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            not_full <= 1'b1;
            sat1     <= 1'b0;
            sat2     <= 1'b0;
            underrun <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            level    <= level_next;
            not_full <= (level_next < LVL_W'(FIFO_DEPTH));
            if (sat_set1)
                sat1 <= 1'b1;
            if (sat_set2)
                sat2 <= 1'b1;
            if (level == '0 && i_data_ready && underrun != 16'hFFFF)
                underrun <= underrun + 16'd1;
        end
    end

    assign o_data           = mem[rd_ptr];
    assign o_data_valid     = (level != '0);
    assign o_fifo_level     = level;
    assign o_sat_ch1        = sat1;
    assign o_sat_ch2        = sat2;
    assign o_underrun_count = underrun;

endmodule
`default_nettype wire

// File: doc/dac_sample_packer.md
Name: dac_sample_packer

Overview:
- Upstream neighbour of the ZmodAWG DAC wrapper, in the DAC clock domain.
- Takes per-channel signed samples from the IAGC gain stage and saturates each to 14 bits.
- Packs both channels into the 32-bit AXI-Stream word format the AWG controller expects.
- Buffers words in a small show-ahead FIFO and drives the wrapper's data/valid inputs; flushes whenever IAGC status reports reset.

Parameters:
- IN_DATA_SIZE, 16: width of signed input samples per channel (must be >= ZMOD_DATA_SIZE).
- ZMOD_DATA_SIZE, 14: DAC sample width.
- AXIS_DATA_SIZE, 32: packed output word width.
- IAGC_STATUS_SIZE, 4: IAGC status bus width.
- FIFO_DEPTH, 8: FIFO entries; power of two, >= 2.

Ports:
- i_dac_clock, input, 1: sole clock, DAC sample clock.
- i_reset, input, 1: asynchronous, active-high reset.
- i_iagc_status, input, IAGC_STATUS_SIZE: IAGC state; 4'b0000 = IAGC reset.
- i_ch1_data, input, IN_DATA_SIZE: channel 1 sample, two's complement.
- i_ch2_data, input, IN_DATA_SIZE: channel 2 sample, two's complement.
- i_data_valid, input, 1: sample pair valid.
- o_data_ready, output, 1: sample pair accepted when high together with i_data_valid.
- o_data, output, AXIS_DATA_SIZE: packed word to DAC.
- o_data_valid, output, 1: o_data valid.
- i_data_ready, input, 1: DAC-side ready (tready).
- o_fifo_level, output, clog2(FIFO_DEPTH)+1: current FIFO occupancy.
- o_sat_ch1, output, 1: sticky flag, a ch1 sample was clipped.
- o_sat_ch2, output, 1: sticky flag, a ch2 sample was clipped.
- o_underrun_count, output, 16: saturating count of underrun cycles.

Behaviour:
- Reset (async assert, sync deassert by clock edge):
  - FIFO empty, o_fifo_level=0, o_data_valid=0, o_data=0.
  - o_data_ready=0, o_sat_ch1=o_sat_ch2=0, o_underrun_count=0.
- Active = (i_iagc_status != 4'b0000).
- Flush: while not Active, every cycle synchronously:
  - FIFO pointers and level cleared; o_data_valid=0; o_data_ready=0.
  - Sat flags cleared; underrun counter cleared.
  - Input and output handshakes ignored.
- Saturation (combinational, per channel):
  - Clamp to [-8192, +8191] (2^(ZMOD_DATA_SIZE-1) bounds).
  - If clipped, set the sticky flag on the accepting cycle.
  - IN_DATA_SIZE == ZMOD_DATA_SIZE gives pass-through and flags never set.
- Packing:
  - o_data[31:18] = ch1_sat, o_data[17:16] = 2'b00.
  - o_data[15:2] = ch2_sat, o_data[1:0] = 2'b00.
- o_data_ready = Active && (level < FIFO_DEPTH), registered from level. It is 0 when full even if a pop happens the same cycle.
- Push = i_data_valid && o_data_ready.
- Pop = o_data_valid && i_data_ready.
- Push and pop in the same cycle: level unchanged, both pointers advance.
- Pointers wrap modulo FIFO_DEPTH.
- FIFO is show-ahead:
  - o_data_valid = (level != 0); o_data = word at the read pointer.
  - o_data holds stable while valid && !ready.
- Latency: a word pushed at edge N appears on o_data with o_data_valid=1 after edge N (1 cycle). A push into an empty FIFO is visible the next cycle, with no bypass.
- Underrun: in a cycle with Active && level==0 && i_data_ready, o_underrun_count increments. It saturates at 16'hFFFF, no wrap.
- Status drop mid-stream: the flush takes priority over a simultaneous push or pop that cycle; data is lost by design.
- Status return to Active: o_data_ready rises on the first Active cycle (level=0).
- i_reset has priority over everything.

Optional Feature:
- Macro: DAC_PACK_TEST_PATTERN_EN.
- With it defined:
  - Extra input port i_pattern_en (1 bit) is added.
  - When i_pattern_en=1 and Active, an internal 14-bit ramp counter replaces the inputs: ch1 = ramp, ch2 = ~ramp, pushed every cycle the FIFO is not full. i_data_valid is ignored and o_data_ready is forced 0.
  - The ramp increments per push and wraps 8191 -> -8192.
  - The ramp resets to 0 on i_reset or flush.
  - Sat flags are unaffected.
- Without it: no port and no ramp logic; behaviour as above.

Test Plan:
- Reset/flush:
  - Drive i_iagc_status=4'b0000 with i_data_valid=1 -> o_data_ready=0, o_data_valid=0, level=0.
  - Set status=4'b0001 -> o_data_ready=1 on the next cycle.
- Packing/latency:
  - Push ch1=16'h0100, ch2=16'hFF00, with i_data_ready=1.
  - Next cycle: o_data_valid=1, o_data=32'h0400_FC00.
  - Sat flags remain 0.
- Saturation:
  - Push ch1=16'h7FFF, ch2=16'h8000.
  - o_data = {14'h1FFF,2'b0,14'h2000,2'b0} = 32'h7FFC_8000.
  - o_sat_ch1=o_sat_ch2=1; both clear after a status drop to 0000.
- Backpressure/full:
  - Hold i_data_ready=0 and push 8 words 1..8 -> level=8, o_data_ready=0.
  - Release -> words emerge in order 1..8, o_data stable while stalled.
- Simultaneous push/pop at level 4 for 20 cycles -> level stays 4 and order is preserved.
- Underrun:
  - Active, FIFO empty, i_data_ready=1 for 10 cycles -> o_underrun_count=10.
  - Status drop mid-burst with level 5 -> level 0 next cycle, counter 0.
